// File: rtl/mem_fill_arbiter.sv
// Arbitrates the shared main memory between I-cache fills, D-cache fills and D-cache write-throughs.
// Grant registered (access one cycle after request seen); fills issue WORDS back-to-back reads and steer returns.
module mem_fill_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic [2:0]        fill_word,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_ack,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

    localparam logic [3:0]        WORDS_C  = 4'(WORDS);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS - 1);

    state_t            state;
    logic              owner;
    logic [ADDR_W-1:0] base;
    logic [3:0]        issue_cnt;
    logic [3:0]        recv_cnt;
    logic [ADDR_W-1:0] miss_base;
    logic              fill_active;
    logic              last_word;

    assign miss_base = (d_miss ? d_miss_addr : i_miss_addr) & BLK_MASK;

    // The first read is issued straight from the grant, so issue_cnt counts words already issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            d_wr_ack  <= 1'b0;
        end else begin
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            d_wr_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_wr_req) begin
                        state     <= WRITE;
                        mem_en    <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= d_wr_addr;
                        mem_wdata <= d_wr_data;
                        d_wr_ack  <= 1'b1;
                    end else if (d_miss || i_miss) begin
                        state     <= FILL;
                        owner     <= d_miss;
                        base      <= miss_base;
                        mem_en    <= 1'b1;
                        mem_addr  <= miss_base;
                        issue_cnt <= 4'd1;
                        recv_cnt  <= 4'd0;
                    end
                end
                WRITE: state <= IDLE;
                FILL: begin
                    if (issue_cnt < WORDS_C) begin
                        mem_en    <= 1'b1;
                        mem_addr  <= base + ADDR_W'({issue_cnt, 1'b0});
                        issue_cnt <= issue_cnt + 4'd1;
                    end
                    if (mem_data_valid) begin
                        recv_cnt <= recv_cnt + 4'd1;
                        if (last_word) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Returns are steered combinationally so each word is written in the cycle it arrives.
    assign fill_active = (state == FILL) && mem_data_valid;
    assign last_word   = (recv_cnt == WORDS_C - 4'd1);
    assign i_fill_we   = fill_active && !owner;
    assign d_fill_we   = fill_active && owner;
    assign i_fill_done = i_fill_we && last_word;
    assign d_fill_done = d_fill_we && last_word;
    assign fill_data   = fill_active ? mem_rdata : '0;
    assign fill_word   = fill_active ? recv_cnt[2:0] : 3'd0;
    assign busy        = (state != IDLE);
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: table vectors, directed corner sequences, then random traffic vs a cycle-offset model.
module tb_mem_fill_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
    logic        mem_data_valid;
    logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;
    logic [2:0]  fill_word;

    always #5 clk = ~clk;

    mem_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .fill_data(fill_data), .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .fill_word(fill_word), .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .d_wr_ack(d_wr_ack), .busy(busy)
    );

    // Pipelined memory with 4-cycle read latency; not reset, so in-flight reads still return.
    function automatic logic [15:0] mdata(input logic [15:0] a);
        return 16'(a * 16'd7) ^ 16'h5A3C;
    endfunction

    logic [3:0]  pv = 4'b0;
    logic [15:0] pa [4];
    always @(posedge clk) begin
        pv[0] <= mem_en && !mem_wr;
        pa[0] <= mem_addr;
        for (int i = 1; i < 4; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign mem_data_valid = pv[3];
    assign mem_rdata      = pv[3] ? mdata(pa[3]) : 16'h0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outv();
        return {24'h0, busy, mem_en, mem_wr, mem_addr, mem_wdata,
                i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack};
    endfunction

    // Per-cycle log of what the DUT did, gathered at the falling edge.
    int          cyc, busy_n, i_we_n, d_we_n, bad_word_n, i_done_c, d_done_c, ack_c;
    int          acc_cyc [$];
    logic [15:0] acc_addr [$];
    logic        acc_wr [$];
    logic [15:0] first_wdata;

    task automatic clear_logs();
        cyc = 0; busy_n = 0; i_we_n = 0; d_we_n = 0; bad_word_n = 0;
        i_done_c = -1; d_done_c = -1; ack_c = -1; first_wdata = 16'h0;
        acc_cyc.delete(); acc_addr.delete(); acc_wr.delete();
    endtask

    function automatic logic [15:0] qa(input int i);
        return (acc_addr.size() > i) ? acc_addr[i] : 16'hDEAD;
    endfunction

    function automatic int qc(input int i);
        return (acc_cyc.size() > i) ? acc_cyc[i] : -1;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        if (busy) busy_n++;
        if (mem_en) begin
            acc_cyc.push_back(cyc);
            acc_addr.push_back(mem_addr);
            acc_wr.push_back(mem_wr);
            if (mem_wr && acc_wr.size() == 1) first_wdata = mem_wdata;
        end
        if (i_fill_we) begin
            if (fill_word != 3'(i_we_n)) bad_word_n++;
            i_we_n++;
        end
        if (d_fill_we) begin
            if (fill_word != 3'(d_we_n)) bad_word_n++;
            d_we_n++;
        end
        if (i_fill_done) begin i_done_c = cyc; i_miss = 1'b0; end
        if (d_fill_done) begin d_done_c = cyc; d_miss = 1'b0; end
        if (d_wr_ack)    begin ack_c = cyc; d_wr_req = 1'b0; end
    endtask

    typedef struct {
        int          kind;      // 0 = I fill, 1 = D fill, 2 = write-through
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_addr0;
        logic        exp_wr;
        int          exp_busy;
        int          exp_we;
    } vec_t;

    vec_t tv [4];

    // Reference model state: what is granted and how many cycles into it we are.
    int          mk, mt;
    logic        mo;
    logic [15:0] mb, mwa, mwd;

    initial begin
        logic [63:0] ev;
        logic        en, we, dn;
        logic [15:0] ea;
        int          errs;

        tv[0] = '{0, 16'h0046, 16'h0000, 16'h0040, 1'b0, 12, 8};
        tv[1] = '{1, 16'hFFFE, 16'h0000, 16'hFFF0, 1'b0, 12, 8};
        tv[2] = '{2, 16'h2002, 16'hBEEF, 16'h2002, 1'b1, 1, 0};
        tv[3] = '{0, 16'h123F, 16'h0000, 16'h1230, 1'b0, 12, 8};

        rst_n = 1'b0; i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
        i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
        #1;
        check("reset_outputs", outv(), 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (6) step();

        // Single-request vectors.
        for (int v = 0; v < 4; v++) begin
            clear_logs();
            case (tv[v].kind)
                0: begin i_miss = 1'b1; i_miss_addr = tv[v].addr; end
                1: begin d_miss = 1'b1; d_miss_addr = tv[v].addr; end
                default: begin d_wr_req = 1'b1; d_wr_addr = tv[v].addr; d_wr_data = tv[v].wdata; end
            endcase
            repeat (16) step();
            check($sformatf("v%0d_first_cycle", v), 64'(qc(0)), 64'd1);
            check($sformatf("v%0d_first_addr", v), 64'(qa(0)), 64'(tv[v].exp_addr0));
            check($sformatf("v%0d_wr", v), 64'(acc_wr.size() > 0 && acc_wr[0]), 64'(tv[v].exp_wr));
            check($sformatf("v%0d_busy", v), 64'(busy_n), 64'(tv[v].exp_busy));
            check($sformatf("v%0d_accesses", v), 64'(acc_addr.size()), (tv[v].kind == 2) ? 64'd1 : 64'd8);
            if (tv[v].kind == 2) begin
                check($sformatf("v%0d_wdata", v), 64'(first_wdata), 64'(tv[v].wdata));
                check($sformatf("v%0d_ack_cycle", v), 64'(ack_c), 64'd1);
                check($sformatf("v%0d_any_we", v), 64'(i_we_n + d_we_n), 64'd0);
            end else begin
                errs = 0;
                for (int k = 0; k < 8; k++) begin
                    if (qa(k) != tv[v].exp_addr0 + 16'(2 * k)) errs++;
                    if (qc(k) != k + 1) errs++;
                end
                check($sformatf("v%0d_addr_seq", v), 64'(errs), 64'd0);
                check($sformatf("v%0d_owner_we", v), 64'((tv[v].kind == 0) ? i_we_n : d_we_n), 64'(tv[v].exp_we));
                check($sformatf("v%0d_other_we", v), 64'((tv[v].kind == 0) ? d_we_n : i_we_n), 64'd0);
                check($sformatf("v%0d_done_cycle", v), 64'((tv[v].kind == 0) ? i_done_c : d_done_c), 64'd12);
                check($sformatf("v%0d_fill_word", v), 64'(bad_word_n), 64'd0);
            end
        end

        // Simultaneous D and I misses: D first, I's first access two cycles after d_fill_done.
        clear_logs();
        d_miss = 1'b1; d_miss_addr = 16'h1234;
        i_miss = 1'b1; i_miss_addr = 16'h0010;
        repeat (30) step();
        check("dual_d_first", 64'(qa(0)), 64'h1230);
        check("dual_d_last", 64'(qa(7)), 64'h123E);
        check("dual_d_done", 64'(d_done_c), 64'd12);
        check("dual_i_addr", 64'(qa(8)), 64'h0010);
        check("dual_i_gap", 64'(qc(8) - d_done_c), 64'd2);
        check("dual_i_done", 64'(i_done_c), 64'd25);

        // Write-through beats a simultaneous D miss; the fill starts two cycles after the write.
        clear_logs();
        d_wr_req = 1'b1; d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF;
        d_miss = 1'b1; d_miss_addr = 16'h3000;
        repeat (20) step();
        check("wp_wr", 64'(acc_wr.size() > 0 && acc_wr[0]), 64'd1);
        check("wp_addr", 64'(qa(0)), 64'h2002);
        check("wp_wdata", 64'(first_wdata), 64'hBEEF);
        check("wp_ack", 64'(ack_c), 64'd1);
        check("wp_fill_addr", 64'(qa(1)), 64'h3000);
        check("wp_fill_start", 64'(qc(1)), 64'd3);

        // Request dropped mid-fill at the top of the address space.
        clear_logs();
        d_miss = 1'b1; d_miss_addr = 16'hFFFE;
        for (int s = 0; s < 16; s++) begin
            step();
            if (cyc == 3) d_miss = 1'b0;
        end
        check("drop_count", 64'(acc_addr.size()), 64'd8);
        check("drop_last", 64'(qa(7)), 64'hFFFE);
        check("drop_done", 64'(d_done_c), 64'd12);
        check("drop_we", 64'(d_we_n), 64'd8);

        // Reset asserted during fill cycle 5; returning data must not be written.
        clear_logs();
        i_miss = 1'b1; i_miss_addr = 16'h0046;
        while (cyc < 6) step();
        rst_n = 1'b0;
        i_miss = 1'b0;
        #1;
        check("rst_mid_outputs", outv(), 64'h0);
        clear_logs();
        for (int s = 0; s < 12; s++) begin
            step();
            if (s == 1) rst_n = 1'b1;
        end
        check("rst_mid_no_we", 64'(i_we_n + d_we_n), 64'd0);
        check("rst_mid_idle", 64'(acc_addr.size()), 64'd0);

        // Random traffic against the cycle-offset model.
        mk = 0; mt = 0; mo = 1'b0; mb = 16'h0; mwa = 16'h0; mwd = 16'h0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            case (mk)
                0: begin
                    if (d_wr_req) begin
                        mk = 1; mwa = d_wr_addr; mwd = d_wr_data;
                    end else if (d_miss || i_miss) begin
                        mk = 2; mt = 0; mo = d_miss;
                        mb = (d_miss ? d_miss_addr : i_miss_addr) & 16'hFFF0;
                    end
                end
                1: mk = 0;
                default: begin
                    if (mt == 11) mk = 0;
                    else mt++;
                end
            endcase
            @(negedge clk);
            if (mk == 1) begin
                ev = {24'h0, 1'b1, 1'b1, 1'b1, mwa, mwd, 5'b00001};
            end else if (mk == 2) begin
                en = (mt < 8);
                ea = en ? mb + 16'(2 * mt) : 16'h0;
                we = (mt >= 4);
                dn = (mt == 11);
                ev = {24'h0, 1'b1, en, 1'b0, ea, 16'h0, we && !mo, we && mo, dn && !mo, dn && mo, 1'b0};
            end else begin
                ev = 64'h0;
            end
            check("rand_outputs", outv(), ev);
            if (mk == 2 && mt >= 4) begin
                check("rand_fill_word", 64'(fill_word), 64'(mt - 4));
                check("rand_fill_data", 64'(fill_data), 64'(mdata(mb + 16'(2 * (mt - 4)))));
            end
            if (d_wr_ack) d_wr_req = 1'b0;
            if (i_fill_done) i_miss = 1'b0;
            if (d_fill_done) d_miss = 1'b0;
            if (!i_miss && $urandom_range(3) == 0) begin
                i_miss = 1'b1; i_miss_addr = 16'($urandom);
            end
            if (!d_miss && $urandom_range(5) == 0) begin
                d_miss = 1'b1; d_miss_addr = 16'($urandom);
            end
            if (!d_wr_req && $urandom_range(4) == 0) begin
                d_wr_req = 1'b1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
